// File: rtl/bus_capture_writer.sv
// bus_capture_writer
// ------------------
// Bus-controlled capture engine. It takes a 16-bit sample stream and writes
// a programmed number of consecutive samples into the write port of a
// bus-readable dual-port RAM. Control and status registers sit on the 16-bit bus.
//
// Register map (byte offset from BASE_ADDR8):
//   0x0 CTRL   (W)   bit0 ARM, bit1 ABORT. Self-clearing strobes; reads 0.
//   0x2 COUNT  (R/W) Samples to capture. A value of 0 or more than DEPTH means DEPTH.
//   0x4 STATUS (R)   bit0 busy, bit1 done, bit2 triggered.
//   0x6 WR_PTR (R)   Samples written by the current or last capture.
//
// Optional feature: define CAPTURE_TRIGGER_EN to add the ARMED state.
// In that state i_Trigger gates the start of capture.
// Without the macro, ARM starts capture directly and i_Trigger is ignored.
//
// Ports:
//   i_Bus_Clk, i_Bus_Rst         clock, synchronous active-high reset
//   i_Bus_CS, i_Bus_Wr_Rd_n,     bus access (1 = write); byte address,
//   i_Bus_Addr8, i_Bus_Wr_Data   bit 0 of the address is ignored
//   o_Bus_Rd_Data, o_Bus_Rd_DV   registered read response, 1-cycle latency
//   i_Sample_DV, i_Sample_Data   sample stream
//   i_Trigger                    level trigger (CAPTURE_TRIGGER_EN only)
//   o_Wr_Addr, o_Wr_DV, o_Wr_Data  RAM write port, 1-cycle latency
//   o_Done                       high while a finished capture is held
module bus_capture_writer #(
  parameter int          DEPTH      = 256,
  parameter logic [15:0] BASE_ADDR8 = 16'h0000,
  localparam int         ADDR_W     = $clog2(DEPTH)
) (
  input  logic              i_Bus_Clk,
  input  logic              i_Bus_Rst,
  input  logic              i_Bus_CS,
  input  logic              i_Bus_Wr_Rd_n,
  input  logic [15:0]       i_Bus_Addr8,
  input  logic [15:0]       i_Bus_Wr_Data,
  output logic [15:0]       o_Bus_Rd_Data,
  output logic              o_Bus_Rd_DV,
  input  logic              i_Sample_DV,
  input  logic [15:0]       i_Sample_Data,
  input  logic              i_Trigger,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic              o_Wr_DV,
  output logic [15:0]       o_Wr_Data,
  output logic              o_Done
);

  // The write pointer needs one extra bit so it can hold DEPTH itself.
  localparam int PTR_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state_reg;
  logic [15:0]       count_reg;
  logic [PTR_W-1:0]  eff_count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic              triggered_reg;
  logic              done_reg;
  logic              wr_dv_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [15:0]       wr_data_reg;
  logic              rd_dv_reg;
  logic [15:0]       rd_data_reg;

  // Address decode. The subtraction wraps, so an address below the base
  // lands far outside the 8-byte window.
  logic [15:0] offset;
  logic        in_window;
  logic [1:0]  reg_sel;
  logic        bus_wr;
  logic        bus_rd;
  logic        arm_req;
  logic        abort_req;
  logic        count_wr;

  assign offset    = i_Bus_Addr8 - BASE_ADDR8;
  assign in_window = (offset[15:3] == 13'd0);
  assign reg_sel   = offset[2:1];
  assign bus_wr    = i_Bus_CS &  i_Bus_Wr_Rd_n & in_window;
  assign bus_rd    = i_Bus_CS & ~i_Bus_Wr_Rd_n & in_window;
  // ABORT takes priority, so a combined ARM+ABORT write never arms.
  assign abort_req = bus_wr && (reg_sel == 2'd0) && i_Bus_Wr_Data[1];
  assign arm_req   = bus_wr && (reg_sel == 2'd0) && i_Bus_Wr_Data[0] && !i_Bus_Wr_Data[1];
  assign count_wr  = bus_wr && (reg_sel == 2'd1);

  logic busy;
  assign busy = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);

  // Effective count, latched at ARM. Out-of-range values mean a full-RAM capture.
  logic [PTR_W-1:0] eff_count_next;
  always_comb begin
    eff_count_next = PTR_W'(count_reg);
    if (count_reg == 16'd0 || 32'(count_reg) > DEPTH)
      eff_count_next = PTR_W'(DEPTH);
  end

  // Capture is enabled in CAPTURE. With the trigger option it is also
  // enabled in the ARMED cycle that sees the trigger, so the sample that
  // arrives with the trigger is kept.
  logic capture_en;
`ifdef CAPTURE_TRIGGER_EN
  assign capture_en = (state_reg == ST_CAPTURE) || ((state_reg == ST_ARMED) && i_Trigger);
`else
  assign capture_en = (state_reg == ST_CAPTURE);
`endif

  logic [PTR_W-1:0] ptr_inc;
  assign ptr_inc = wr_ptr_reg + PTR_W'(1);

  logic [15:0] rd_mux;
  always_comb begin
    rd_mux = 16'd0;
    case (reg_sel)
      2'd1:    rd_mux = count_reg;
      2'd2:    rd_mux = {13'd0, triggered_reg, done_reg, busy};
      2'd3:    rd_mux = 16'(wr_ptr_reg);
      default: rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= 16'd0;
      eff_count_reg <= '0;
      wr_ptr_reg    <= '0;
      triggered_reg <= 1'b0;
      done_reg      <= 1'b0;
      wr_dv_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= 16'd0;
      rd_dv_reg     <= 1'b0;
      rd_data_reg   <= 16'd0;
    end else begin
      wr_dv_reg   <= 1'b0;
      rd_dv_reg   <= bus_rd;
      rd_data_reg <= bus_rd ? rd_mux : 16'd0;

      if (count_wr && !busy)
        count_reg <= i_Bus_Wr_Data;

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (arm_req) begin
            wr_ptr_reg    <= '0;
            eff_count_reg <= eff_count_next;
            triggered_reg <= 1'b0;
            done_reg      <= 1'b0;
`ifdef CAPTURE_TRIGGER_EN
            state_reg     <= ST_ARMED;
`else
            state_reg     <= ST_CAPTURE;
`endif
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          if (abort_req) begin
            state_reg <= ST_IDLE;
          end else begin
`ifdef CAPTURE_TRIGGER_EN
            if (state_reg == ST_ARMED && i_Trigger) begin
              state_reg     <= ST_CAPTURE;
              triggered_reg <= 1'b1;
            end
`endif
            if (capture_en && i_Sample_DV) begin
              wr_dv_reg   <= 1'b1;
              wr_addr_reg <= wr_ptr_reg[ADDR_W-1:0];
              wr_data_reg <= i_Sample_Data;
              wr_ptr_reg  <= ptr_inc;
              // This check comes last, so the final write overrides the
              // move to CAPTURE in the same cycle.
              if (ptr_inc == eff_count_reg) begin
                state_reg <= ST_DONE;
                done_reg  <= 1'b1;
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_Wr_DV       = wr_dv_reg;
  assign o_Wr_Addr     = wr_addr_reg;
  assign o_Wr_Data     = wr_data_reg;
  assign o_Done        = done_reg;
  assign o_Bus_Rd_DV   = rd_dv_reg;
  assign o_Bus_Rd_Data = rd_data_reg;

  // Byte-lane bit of the address and, in the default build, the trigger
  // input are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{offset[0], i_Trigger};

endmodule

// File: tb/tb_bus_capture_writer.sv
module tb_bus_capture_writer;

  localparam int DEPTH = 256;
`ifdef CAPTURE_TRIGGER_EN
  localparam logic TRIG = 1'b1;
`else
  localparam logic TRIG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [15:0] wdata = 16'd0;
  logic [15:0] rd_data;
  logic        rd_dv;
  logic        smp_dv = 1'b0;
  logic [15:0] smp_data = 16'd0;
  logic        trig = 1'b0;
  logic [7:0]  wr_addr;
  logic        wr_dv;
  logic [15:0] wr_data;
  logic        done;

  bus_capture_writer #(.DEPTH(DEPTH), .BASE_ADDR8(16'h0000)) dut (
    .i_Bus_Clk(clk), .i_Bus_Rst(rst), .i_Bus_CS(cs), .i_Bus_Wr_Rd_n(wr),
    .i_Bus_Addr8(addr), .i_Bus_Wr_Data(wdata), .o_Bus_Rd_Data(rd_data),
    .o_Bus_Rd_DV(rd_dv), .i_Sample_DV(smp_dv), .i_Sample_Data(smp_data),
    .i_Trigger(trig), .o_Wr_Addr(wr_addr), .o_Wr_DV(wr_dv),
    .o_Wr_Data(wr_data), .o_Done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // RAM-side monitor: records every write the DUT issues.
  logic [15:0] cap_mem [0:DEPTH-1];
  int total_writes = 0;
  int last_addr = -1;
  always @(negedge clk) begin
    if (wr_dv === 1'b1) begin
      cap_mem[wr_addr] = wr_data;
      total_writes++;
      last_addr = int'(wr_addr);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    $display("bus wr addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic dv);
    cs = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    d = rd_data; dv = rd_dv;
    cs = 1'b0;
    $display("bus rd addr=%h data=%h dv=%b", a, d, dv);
  endtask

  task automatic stream(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      smp_dv = 1'b1; smp_data = base + 16'(i);
      tick();
    end
    smp_dv = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] d; logic dv; int w0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    w0 = total_writes;
    for (int r = 0; r < 4; r++) begin
      bus_read(16'(2 * r), d, dv);
      vectors++;
      if (dv !== 1'b1 || d !== 16'h0000) begin
        miscompares++; $display("FAIL reset_reg%0d: got dv=%b data=%h, want dv=1 data=0000", r, dv, d);
      end
    end
    bus_read(16'h0008, d, dv);
    vectors++;
    if (dv !== 1'b0 || d !== 16'h0000) begin
      miscompares++; $display("FAIL out_of_window_read: got dv=%b data=%h, want dv=0 data=0000", dv, d);
    end
    tick();
    vectors++;
    if (total_writes != w0 || done !== 1'b0) begin
      miscompares++; $display("FAIL reset_no_write: got writes=%0d done=%b, want 0 and 0", total_writes - w0, done);
    end
  endtask

  task automatic test_basic();
    logic [15:0] d; logic dv; int w0;
    trig = 1'b1;
    bus_write(16'h0002, 16'd4);
    bus_read(16'h0002, d, dv);
    vectors++;
    if (dv !== 1'b1 || d !== 16'd4) begin
      miscompares++; $display("FAIL count_readback: got %h, want 0004", d);
    end
    w0 = total_writes;
    bus_write(16'h0000, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      smp_dv = 1'b1; smp_data = 16'hA000 + 16'(i);
      tick();
      vectors++;
      if (wr_dv !== (i < 4) || done !== (i >= 3)) begin
        miscompares++; $display("FAIL basic_cycle%0d_dv_done: got dv=%b done=%b, want dv=%b done=%b", i, wr_dv, done, (i < 4), (i >= 3));
      end
      if (i < 4) begin
        vectors++;
        if (wr_addr !== 8'(i) || wr_data !== 16'hA000 + 16'(i)) begin
          miscompares++; $display("FAIL basic_cycle%0d_write: got addr=%h data=%h, want addr=%h data=%h", i, wr_addr, wr_data, 8'(i), 16'hA000 + 16'(i));
        end
      end
    end
    smp_dv = 1'b0;
    tick();
    bus_read(16'h0004, d, dv);
    vectors++;
    if (d !== (TRIG ? 16'h0006 : 16'h0002)) begin
      miscompares++; $display("FAIL basic_status: got %h, want %h", d, TRIG ? 16'h0006 : 16'h0002);
    end
    bus_read(16'h0006, d, dv);
    vectors++;
    if (d !== 16'd4) begin
      miscompares++; $display("FAIL basic_wr_ptr: got %h, want 0004", d);
    end
    vectors++;
    if (total_writes - w0 != 4) begin
      miscompares++; $display("FAIL basic_write_count: got %0d, want 4", total_writes - w0);
    end
  endtask

  task automatic test_full_depth();
    logic [15:0] d; logic dv; int w0;
    trig = 1'b1;
    bus_write(16'h0002, 16'd0);
    w0 = total_writes;
    bus_write(16'h0000, 16'h0001);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL rearm_clears_done: got %b, want 0", done);
    end
    stream(260, 16'h1000);
    vectors++;
    if (total_writes - w0 != 256 || last_addr != 255) begin
      miscompares++; $display("FAIL full_count: got writes=%0d last=%0d, want 256 and 255", total_writes - w0, last_addr);
    end
    vectors++;
    if (cap_mem[0] !== 16'h1000 || cap_mem[255] !== 16'h10FF) begin
      miscompares++; $display("FAIL full_data: got [0]=%h [255]=%h, want 1000 10FF", cap_mem[0], cap_mem[255]);
    end
    bus_read(16'h0006, d, dv);
    vectors++;
    if (d !== 16'h0100) begin
      miscompares++; $display("FAIL full_wr_ptr: got %h, want 0100", d);
    end
    bus_read(16'h0004, d, dv);
    vectors++;
    if (d !== (TRIG ? 16'h0006 : 16'h0002)) begin
      miscompares++; $display("FAIL full_status: got %h, want %h", d, TRIG ? 16'h0006 : 16'h0002);
    end
  endtask

`ifdef CAPTURE_TRIGGER_EN
  task automatic test_trigger();
    logic [15:0] d; logic dv; int w0;
    trig = 1'b0;
    bus_write(16'h0002, 16'd2);
    w0 = total_writes;
    bus_write(16'h0000, 16'h0001);
    bus_read(16'h0004, d, dv);
    vectors++;
    if (d !== 16'h0001) begin
      miscompares++; $display("FAIL armed_status: got %h, want 0001", d);
    end
    stream(3, 16'hC000);
    vectors++;
    if (total_writes != w0) begin
      miscompares++; $display("FAIL pre_trigger_writes: got %0d, want 0", total_writes - w0);
    end
    trig = 1'b1;
    stream(2, 16'hB000);
    trig = 1'b0;
    vectors++;
    if (total_writes - w0 != 2 || last_addr != 1 || cap_mem[0] !== 16'hB000 || cap_mem[1] !== 16'hB001) begin
      miscompares++; $display("FAIL trigger_writes: got n=%0d last=%0d [0]=%h [1]=%h, want 2 1 B000 B001", total_writes - w0, last_addr, cap_mem[0], cap_mem[1]);
    end
    bus_read(16'h0004, d, dv);
    vectors++;
    if (d !== 16'h0006) begin
      miscompares++; $display("FAIL trigger_status: got %h, want 0006", d);
    end
  endtask
`else
  task automatic test_trigger();
    logic [15:0] d; logic dv; int w0;
    trig = 1'b0;
    bus_write(16'h0002, 16'd2);
    w0 = total_writes;
    bus_write(16'h0000, 16'h0001);
    stream(3, 16'hD000);
    vectors++;
    if (total_writes - w0 != 2 || cap_mem[0] !== 16'hD000 || cap_mem[1] !== 16'hD001) begin
      miscompares++; $display("FAIL no_trigger_writes: got n=%0d [0]=%h [1]=%h, want 2 D000 D001", total_writes - w0, cap_mem[0], cap_mem[1]);
    end
    bus_read(16'h0004, d, dv);
    vectors++;
    if (d !== 16'h0002) begin
      miscompares++; $display("FAIL no_trigger_status: got %h, want 0002", d);
    end
  endtask
`endif

  task automatic test_abort();
    logic [15:0] d; logic dv; int w0;
    trig = 1'b1;
    bus_write(16'h0002, 16'd8);
    w0 = total_writes;
    bus_write(16'h0000, 16'h0001);
    stream(3, 16'hE000);
    bus_write(16'h0002, 16'd5);
    bus_read(16'h0002, d, dv);
    vectors++;
    if (d !== 16'd8) begin
      miscompares++; $display("FAIL count_write_while_busy: got %h, want 0008", d);
    end
    bus_write(16'h0000, 16'h0001);
    bus_read(16'h0006, d, dv);
    vectors++;
    if (d !== 16'd3) begin
      miscompares++; $display("FAIL arm_while_busy_wr_ptr: got %h, want 0003", d);
    end
    bus_write(16'h0000, 16'h0002);
    bus_read(16'h0004, d, dv);
    vectors++;
    if (d !== (TRIG ? 16'h0004 : 16'h0000)) begin
      miscompares++; $display("FAIL abort_status: got %h, want %h", d, TRIG ? 16'h0004 : 16'h0000);
    end
    bus_write(16'h0000, 16'h0003);
    bus_read(16'h0004, d, dv);
    vectors++;
    if (d !== (TRIG ? 16'h0004 : 16'h0000)) begin
      miscompares++; $display("FAIL arm_abort_status: got %h, want %h", d, TRIG ? 16'h0004 : 16'h0000);
    end
    bus_read(16'h0006, d, dv);
    vectors++;
    if (d !== 16'd3) begin
      miscompares++; $display("FAIL abort_wr_ptr: got %h, want 0003", d);
    end
    stream(5, 16'hE100);
    vectors++;
    if (total_writes - w0 != 3 || cap_mem[2] !== 16'hE002) begin
      miscompares++; $display("FAIL abort_writes: got n=%0d [2]=%h, want 3 E002", total_writes - w0, cap_mem[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic dv; int w0;
    trig = 1'b1;
    bus_write(16'h0002, 16'd8);
    w0 = total_writes;
    bus_write(16'h0000, 16'h0001);
    smp_dv = 1'b1; smp_data = 16'hF000; tick();
    smp_data = 16'hF001; tick();
    rst = 1'b1; smp_data = 16'hF002; tick();
    vectors++;
    if (wr_dv !== 1'b0) begin
      miscompares++; $display("FAIL reset_cycle_write: got dv=%b, want 0", wr_dv);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    smp_dv = 1'b0;
    tick();
    vectors++;
    if (total_writes - w0 != 2 || done !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_writes: got n=%0d done=%b, want 2 and 0", total_writes - w0, done);
    end
    for (int r = 0; r < 4; r++) begin
      bus_read(16'(2 * r), d, dv);
      vectors++;
      if (dv !== 1'b1 || d !== 16'h0000) begin
        miscompares++; $display("FAIL reset_mid_reg%0d: got dv=%b data=%h, want dv=1 data=0000", r, dv, d);
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_full_depth();
    test_trigger();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_capture_writer.md
# bus_capture_writer

Bus-controlled sample capture engine that fills the write port of the 16-bit bus-readable dual-port RAM. It accepts a 16-bit sample stream, applies an optional trigger, writes a programmed number of consecutive samples to sequential RAM addresses, and exposes control and status registers on the 16-bit bus. Software arms it, polls status, then reads the captured samples back through the RAM's read port.

## Interface
- DEPTH, 256: RAM depth in 16-bit words; ADDR_W = $clog2(DEPTH).
- BASE_ADDR8, 16'h0000: byte address of register 0; the block decodes BASE_ADDR8..BASE_ADDR8+7.
- i_Bus_Clk  in  1  single clock for all logic.
- i_Bus_Rst  in  1  synchronous, active-high reset.
- i_Bus_CS  in  1  bus chip select.
- i_Bus_Wr_Rd_n  in  1  1 = write, 0 = read.
- i_Bus_Addr8  in  16  byte address; bit 0 ignored.
- i_Bus_Wr_Data  in  16  bus write data.
- o_Bus_Rd_Data  out  16  register read data.
- o_Bus_Rd_DV  out  1  read data valid.
- i_Sample_DV  in  1  sample strobe.
- i_Sample_Data  in  16  sample value.
- i_Trigger  in  1  level trigger (used only with CAPTURE_TRIGGER_EN).
- o_Wr_Addr  out  ADDR_W  RAM write address.
- o_Wr_DV  out  1  RAM write enable.
- o_Wr_Data  out  16  RAM write data.
- o_Done  out  1  high while in DONE.

## Operation
- Registers (offset from BASE_ADDR8):
  - 0x0 CTRL (W): bit0 ARM, bit1 ABORT; self-clearing strobes, read returns 0.
  - 0x2 COUNT (R/W): samples to capture; 0 or > DEPTH means DEPTH. Reset 0.
  - 0x4 STATUS (R): bit0 busy (ARMED or CAPTURE), bit1 done, bit2 triggered; others 0.
  - 0x6 WR_PTR (R): number of samples written in current/last capture, zero-extended.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: ARM -> ARMED (with trigger) or CAPTURE (without); WR_PTR cleared to 0 on ARM.
  - ARMED: i_Trigger high -> CAPTURE; triggered bit set. A sample with DV in the trigger cycle is captured.
  - CAPTURE: each i_Sample_DV writes i_Sample_Data to address WR_PTR, WR_PTR += 1; after write number N (effective COUNT) -> DONE.
  - DONE: holds; ARM restarts a capture (same as from IDLE).
  - ABORT in ARMED/CAPTURE -> IDLE, WR_PTR holds the value reached.
- ARM while busy ignored. ARM and ABORT in same write: ABORT wins.
- COUNT writes while busy ignored; the effective count is latched at ARM.
- Address wrap-around cannot occur: WR_PTR never exceeds DEPTH; o_Wr_Addr = WR_PTR[ADDR_W-1:0] before increment.
- Samples outside CAPTURE are discarded.
- Bus accesses outside the decoded window: no read response, no write effect.

## Timing
- Reset: state IDLE, COUNT 0, WR_PTR 0, triggered 0, all outputs 0.
- Reset mid-capture aborts immediately; no RAM write in the reset cycle or after it.
- Sample capture latency 1 cycle: DV sampled at edge k -> o_Wr_DV/o_Wr_Addr/o_Wr_Data valid for cycle k+1, single-cycle pulse.
- State enters DONE on the edge that registers the last write; o_Done rises with that write's o_Wr_DV.
- Back-to-back samples (DV every cycle) supported at full rate.
- Bus read latency 1 cycle: CS & read at edge k -> o_Bus_Rd_DV pulses one cycle with data at k+1; o_Bus_Rd_Data 0 when DV low.
- Bus write takes effect on the CS edge; ARM -> ARMED/CAPTURE on next cycle; first sample may be accepted the cycle after ARM.

## Configuration
- CAPTURE_TRIGGER_EN defined: ARMED state present, i_Trigger gates capture start, STATUS bit2 live.
- Not defined: ARM goes IDLE -> CAPTURE directly, i_Trigger ignored, STATUS bit2 reads 0.

## Test plan
- Reset, read all four registers -> CTRL 0, COUNT 0, STATUS 0, WR_PTR 0; o_Wr_DV never asserted.
- COUNT=4, ARM, 6 consecutive samples 0xA000..0xA005 -> writes 0xA000..0xA003 to addr 0..3, o_Done high, STATUS=0x2 (0x6 with trigger), WR_PTR=4.
- COUNT=0 with DEPTH=256, continuous samples -> exactly 256 writes, last addr 255, WR_PTR=256, no wrap.
- CAPTURE_TRIGGER_EN: ARM, 3 samples with trigger low, then trigger high with 2 samples, COUNT=2 -> only the 2 post-trigger samples written, addr 0..1.
- COUNT=8, ARM, 3 samples, ABORT -> IDLE, WR_PTR=3, further samples not written; ARM+ABORT in same write -> stays IDLE.
- Reset asserted after 2 of 8 samples -> no further writes, all registers back to reset values.
